cpu_control_sequencer: RTL and testbench
========================================

// Module: cpu_control_sequencer
// PURPOSE
//  Fetch/decode/execute control FSM for the 4-bit CPU. Consumes the 8-bit instruction word
//  from program ROM and drives the load-enable inputs of the 4-bit parallel registers:
//  A, B, OUT and PC. It also drives the ALU op select and the data-bus source select.
//  Holds the instruction register and the C/Z flags internally.
// PARAMETERS
//  PC_W      4   program counter / ROM address width
//  START_PC  0   PC value loaded on the first cycle after reset
// PORTS
//  clk        in   1  system clock, rising edge
//  reset      in   1  asynchronous, active-low; clears FSM, IR, flags, PC
//  run        in   1  1 = leave FETCH and execute; 0 = park in FETCH, no enables
//  instr      in   8  ROM data: [7:4] opcode, [3:0] immediate
//  alu_carry  in   1  carry/borrow out of the ALU, valid during EXEC
//  alu_zero   in   1  ALU result == 0, valid during EXEC
//  pc         out  PC_W  program counter (ROM address)
//  imm        out  4  IR[3:0], to the data bus when src_sel=IMM
//  a_en       out  1  load enable, register A
//  b_en       out  1  load enable, register B
//  out_en     out  1  load enable, output register
//  alu_op     out  2  00 ADD, 01 SUB, 10 AND, 11 OR
//  src_sel    out  2  bus source: 00 IMM, 01 ALU, 10 A, 11 B
//  c_flag     out  1  registered carry flag
//  z_flag     out  1  registered zero flag
//  halted     out  1  1 while in HALT
//  state      out  2  00 START, 01 FETCH, 10 EXEC, 11 HALT (debug)
// BEHAVIOUR
//  - Reset (async, reset=0): state=START, pc=START_PC, IR=8'h00, c/z=0. All enables 0,
//    alu_op=00, src_sel=00, halted=0.
//  - All outputs decode only from registered state/IR/flags. Never from instr. Glitch-free.
//  - START: 1 cycle, no enables, -> FETCH.
//  - FETCH: if run=1, IR<=instr, pc<=pc+1 (wraps 4'hF->4'h0), -> EXEC.
//    If run=0, hold state, IR and pc.
//  - EXEC: 1 cycle, then -> FETCH (HLT -> HALT). Enables are 1-cycle pulses in EXEC only.
//    0x0 NOP  none
//    0x1 LDA  src=IMM, a_en
//    0x2 LDB  src=IMM, b_en
//    0x3 ADD  src=ALU, op=00, a_en, flags update
//    0x4 SUB  src=ALU, op=01, a_en, flags update
//    0x5 AND  src=ALU, op=10, a_en, flags update
//    0x6 OR   src=ALU, op=11, a_en, flags update
//    0x7 OUT  src=A, out_en
//    0x8 MOV  src=A, b_en
//    0x9 JMP  pc<=imm
//    0xA JC   pc<=imm if c_flag
//    0xB JZ   pc<=imm if z_flag
//    0xF HLT  -> HALT
//    0xC-0xE  treated as NOP
//  - Flag update: c<=alu_carry, z<=alu_zero at the end of EXEC for ADD/SUB/AND/OR only.
//    AND/OR force c<=0. Other opcodes hold both flags.
//  - Jumps use flags as registered before this EXEC cycle. Branch target takes effect on the
//    next FETCH; the increment done in FETCH is overwritten.
//  - HALT: all enables 0, pc/IR/flags frozen, halted=1. Exited only by reset; run is ignored.
//  - Throughput: 2 cycles per instruction with run=1. Reset mid-EXEC aborts the instruction
//    with no enable pulse after reset asserts.
// TESTING
//  1 Reset: reset=0 mid-EXEC of ADD -> a_en drops immediately; state=00, pc=0, flags 0.
//  2 LDA 5, LDB 3, ADD, OUT -> a_en/b_en/out_en one pulse each in EXEC, op=00 on ADD;
//    pc=4 after 8 cycles.
//  3 SUB with alu_carry=1, alu_zero=1, then JZ 0xA -> z=1, c=1, pc=0xA on the next FETCH.
//    JC 0x2 with c=0 -> falls through.
//  4 PC wrap: JMP 0xF, then NOP at 0xF -> pc goes 0xF -> 0x0.
//  5 run=0 for 5 cycles in FETCH -> IR, pc, state unchanged, no enables. run=1 resumes.
//  6 HLT (0xF0) -> halted=1 and no enables for 20 cycles regardless of run/instr;
//    reset exits to START.

Source files
------------

// File: rtl/cpu_control_sequencer.sv
// cpu_control_sequencer
//   Fetch/decode/execute control FSM for the 4-bit CPU. It latches the ROM
//   instruction word into an internal IR during FETCH. During the single EXEC
//   cycle it pulses the load enables of the A, B and OUT registers. It also
//   selects the ALU operation and the data-bus source, keeps the C/Z flags, and
//   steps or branches the program counter.
//
//   Ports
//     clk        system clock, rising edge
//     reset      asynchronous, active-low; clears FSM, IR, flags and PC
//     run        1 = leave FETCH and execute, 0 = park in FETCH
//     instr      ROM data word: [7:4] opcode, [3:0] immediate
//     alu_carry  ALU carry/borrow, sampled at the end of EXEC
//     alu_zero   ALU zero result, sampled at the end of EXEC
//     pc         program counter (ROM address)
//     imm        IR immediate field, driven onto the bus when src_sel=IMM
//     a_en, b_en, out_en  register load enables (1-cycle pulses in EXEC)
//     alu_op     00 ADD, 01 SUB, 10 AND, 11 OR
//     src_sel    bus source: 00 IMM, 01 ALU, 10 A, 11 B
//     c_flag, z_flag      registered carry / zero flags
//     halted     1 while in HALT
//     state      debug view of the FSM: 00 START, 01 FETCH, 10 EXEC, 11 HALT
module cpu_control_sequencer #(
  parameter int                 PC_W     = 4,
  parameter logic [PC_W-1:0]    START_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic [7:0]      instr,
  input  logic            alu_carry,
  input  logic            alu_zero,
  output logic [PC_W-1:0] pc,
  output logic [3:0]      imm,
  output logic            a_en,
  output logic            b_en,
  output logic            out_en,
  output logic [1:0]      alu_op,
  output logic [1:0]      src_sel,
  output logic            c_flag,
  output logic            z_flag,
  output logic            halted,
  output logic [1:0]      state
);

  typedef enum logic [1:0] {
    S_START = 2'b00,
    S_FETCH = 2'b01,
    S_EXEC  = 2'b10,
    S_HALT  = 2'b11
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h1, OP_LDB = 4'h2, OP_ADD = 4'h3,
                         OP_SUB = 4'h4, OP_AND = 4'h5, OP_OR  = 4'h6,
                         OP_OUT = 4'h7, OP_MOV = 4'h8, OP_JMP = 4'h9,
                         OP_JC  = 4'hA, OP_JZ  = 4'hB, OP_HLT = 4'hF;

  localparam logic [1:0] SRC_IMM = 2'b00, SRC_ALU = 2'b01, SRC_A = 2'b10;

  state_t          st, st_nxt;
  logic [7:0]      ir, ir_nxt;
  logic [PC_W-1:0] pc_r, pc_nxt;
  logic            c_r, c_nxt, z_r, z_nxt;
  logic [3:0]      opc;

  assign opc    = ir[7:4];
  assign imm    = ir[3:0];
  assign pc     = pc_r;
  assign c_flag = c_r;
  assign z_flag = z_r;
  assign state  = st;
  assign halted = (st == S_HALT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st   <= S_START;
      ir   <= 8'h00;
      pc_r <= START_PC;
      c_r  <= 1'b0;
      z_r  <= 1'b0;
    end else begin
      st   <= st_nxt;
      ir   <= ir_nxt;
      pc_r <= pc_nxt;
      c_r  <= c_nxt;
      z_r  <= z_nxt;
    end
  end

  // Outputs depend only on registered state/IR/flags, so the ROM word
  // arriving on instr can never disturb the enables.
  always_comb begin
    st_nxt  = st;
    ir_nxt  = ir;
    pc_nxt  = pc_r;
    c_nxt   = c_r;
    z_nxt   = z_r;
    a_en    = 1'b0;
    b_en    = 1'b0;
    out_en  = 1'b0;
    alu_op  = 2'b00;
    src_sel = SRC_IMM;

    unique case (st)
      S_START: begin
        pc_nxt = START_PC;
        st_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (run) begin
          ir_nxt = instr;
          pc_nxt = pc_r + PC_W'(1);
          st_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        st_nxt = S_FETCH;
        case (opc)
          OP_LDA: a_en = 1'b1;
          OP_LDB: b_en = 1'b1;
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            src_sel = SRC_ALU;
            alu_op  = opc[1:0] + 2'b01;  // 3,4,5,6 -> 00,01,10,11
            a_en    = 1'b1;
            z_nxt   = alu_zero;
            // Logical ops have no meaningful carry.
            c_nxt   = (opc == OP_ADD || opc == OP_SUB) ? alu_carry : 1'b0;
          end
          OP_OUT: begin
            src_sel = SRC_A;
            out_en  = 1'b1;
          end
          OP_MOV: begin
            src_sel = SRC_A;
            b_en    = 1'b1;
          end
          // Branches overwrite the increment made during FETCH and test the
          // flags as they stood before this cycle.
          OP_JMP: pc_nxt = PC_W'(ir[3:0]);
          OP_JC:  if (c_r) pc_nxt = PC_W'(ir[3:0]);
          OP_JZ:  if (z_r) pc_nxt = PC_W'(ir[3:0]);
          OP_HLT: st_nxt = S_HALT;
          default: ;
        endcase
      end
      S_HALT: ;
      default: st_nxt = S_START;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_sequencer.sv
module tb_cpu_control_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [7:0] instr;
  logic       alu_carry;
  logic       alu_zero;
  logic [3:0] pc;
  logic [3:0] imm;
  logic       a_en, b_en, out_en;
  logic [1:0] alu_op, src_sel;
  logic       c_flag, z_flag, halted;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cpu_control_sequencer #(.PC_W(4), .START_PC(4'h0)) dut (
    .clk(clk), .reset(reset), .run(run), .instr(instr),
    .alu_carry(alu_carry), .alu_zero(alu_zero),
    .pc(pc), .imm(imm), .a_en(a_en), .b_en(b_en), .out_en(out_en),
    .alu_op(alu_op), .src_sel(src_sel), .c_flag(c_flag), .z_flag(z_flag),
    .halted(halted), .state(state)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Enables packed as {a_en,b_en,out_en}.
  function automatic logic [7:0] ens();
    return 8'({a_en, b_en, out_en});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; run = 1'b0; instr = 8'h00; alu_carry = 1'b0; alu_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 8'(state), 8'h0);
    check("rst_pc", 8'(pc), 8'h0);
    check("rst_flags", 8'({c_flag, z_flag}), 8'h0);
    check("rst_en", ens(), 8'h0);
    check("rst_halt", 8'(halted), 8'h0);
    check("rst_sel", 8'({alu_op, src_sel}), 8'h0);
    reset = 1'b1;
    tick();
    check("start_to_fetch", 8'(state), 8'h1);

    // LDA 5, LDB 3, ADD, OUT
    run = 1'b1; instr = 8'h15; tick();
    check("lda_state", 8'(state), 8'h2);
    check("lda_en", ens(), 8'h4);
    check("lda_src", 8'(src_sel), 8'h0);
    check("lda_imm", 8'(imm), 8'h5);
    check("lda_pc", 8'(pc), 8'h1);
    tick();
    check("fetch_no_en", ens(), 8'h0);
    instr = 8'h23; tick();
    check("ldb_en", ens(), 8'h2);
    check("ldb_imm", 8'(imm), 8'h3);
    tick();
    instr = 8'h30; tick();
    check("add_en", ens(), 8'h4);
    check("add_sel", 8'({alu_op, src_sel}), 8'b0001);
    tick();
    instr = 8'h70; tick();
    check("out_en", ens(), 8'h1);
    check("out_src", 8'(src_sel), 8'h2);
    tick();
    check("pc_after_4", 8'(pc), 8'h4);

    // SUB sets C and Z, JZ taken
    instr = 8'h40; tick();
    alu_carry = 1'b1; alu_zero = 1'b1;
    check("sub_sel", 8'({alu_op, src_sel}), 8'b0101);
    check("sub_en", ens(), 8'h4);
    tick();
    check("sub_flags", 8'({c_flag, z_flag}), 8'h3);
    alu_carry = 1'b0; alu_zero = 1'b0;
    instr = 8'hBA; tick();
    check("jz_en", ens(), 8'h0);
    check("jz_pc_inc", 8'(pc), 8'h6);
    tick();
    check("jz_taken", 8'(pc), 8'hA);
    // AND forces C to 0, then JC falls through
    instr = 8'h50; tick();
    alu_carry = 1'b1; alu_zero = 1'b0;
    check("and_op", 8'(alu_op), 8'h2);
    tick();
    check("and_flags", 8'({c_flag, z_flag}), 8'h0);
    alu_carry = 1'b0;
    instr = 8'hA2; tick(); tick();
    check("jc_not_taken", 8'(pc), 8'hC);

    // PC wrap
    instr = 8'h9F; tick(); tick();
    check("jmp_pc", 8'(pc), 8'hF);
    instr = 8'h00; tick();
    check("wrap_pc", 8'(pc), 8'h0);
    check("nop_en", ens(), 8'h0);
    tick();

    // run=0 parks in FETCH
    run = 1'b0; instr = 8'h15;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("park_state", 8'(state), 8'h1);
      check("park_pc", 8'(pc), 8'h0);
      check("park_ir", 8'(imm), 8'h0);
      check("park_en", ens(), 8'h0);
    end
    run = 1'b1; tick();
    check("resume_state", 8'(state), 8'h2);
    check("resume_en", ens(), 8'h4);
    check("resume_imm", 8'(imm), 8'h5);
    tick();

    // Reset mid-EXEC of ADD
    instr = 8'h40; tick();
    alu_carry = 1'b1; alu_zero = 1'b1;
    tick();
    check("pre_rst_flags", 8'({c_flag, z_flag}), 8'h3);
    alu_carry = 1'b0; alu_zero = 1'b0;
    instr = 8'h30; tick();
    check("add2_en", ens(), 8'h4);
    #2 reset = 1'b0;
    #1;
    check("midrst_en", ens(), 8'h0);
    check("midrst_state", 8'(state), 8'h0);
    check("midrst_pc", 8'(pc), 8'h0);
    check("midrst_flags", 8'({c_flag, z_flag}), 8'h0);
    reset = 1'b1;
    tick();
    check("rst2_fetch", 8'(state), 8'h1);

    // HLT
    instr = 8'hF0; tick();
    check("hlt_exec_halted", 8'(halted), 8'h0);
    tick();
    check("halt_state", 8'(state), 8'h3);
    for (int i = 0; i < 20; i++) begin
      run = 1'($urandom_range(0, 1));
      instr = 8'($urandom);
      alu_carry = 1'($urandom_range(0, 1));
      alu_zero = 1'($urandom_range(0, 1));
      tick();
      check("halt_halted", 8'(halted), 8'h1);
      check("halt_en", ens(), 8'h0);
      check("halt_pc", 8'(pc), 8'h1);
      check("halt_ir", 8'(imm), 8'h0);
      check("halt_flags", 8'({c_flag, z_flag}), 8'h0);
    end
    reset = 1'b0;
    #1;
    check("halt_rst_state", 8'(state), 8'h0);
    check("halt_rst_halted", 8'(halted), 8'h0);
    reset = 1'b1; run = 1'b0;
    tick();
    check("post_halt_fetch", 8'(state), 8'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
